// File: rtl/rdata_chan_mngr.sv
// Manager-side AXI read data receiver: assembles 4-beat x 32-bit R bursts into a
// 128-bit line, holds it until acknowledged, and flags rlast/rid protocol errors.
module rdata_chan_mngr #(
  parameter int BEAT_W = 32,
  parameter int BURST  = 4,
  parameter int ID_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rvalid,
  output logic                      rready,
  input  logic [ID_W-1:0]           rid,
  input  logic [BEAT_W-1:0]         rdata,
  input  logic                      rlast,
  output logic                      rdata_m_valid,
  output logic [ID_W-1:0]           rdata_m_id,
  output logic [BEAT_W*BURST-1:0]   rdata_m_data,
  input  logic                      rdata_m_ack,
  output logic                      rdata_m_err,
  input  logic                      err_clr
);

  localparam int LINE_W = BEAT_W * BURST;

  typedef enum logic [1:0] {
    RIDLE = 2'd0,
    RRECV = 2'd1,
    RHOLD = 2'd2,
    RDEFO = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [1:0]          beat_cnt_r;
  logic [1:0]          beat_cnt_nxt_s;
  logic [LINE_W-1:0]   line_nxt_s;
  logic [ID_W-1:0]     id_nxt_s;
  logic                err_set_s;
  logic                err_nxt_s;
  logic                accept_s;

  // Insert one beat into its lane, leaving the other lanes untouched.
  function automatic logic [LINE_W-1:0] lane_write(
    input logic [LINE_W-1:0] line,
    input logic [1:0]        idx,
    input logic [BEAT_W-1:0] beat
  );
    logic [LINE_W-1:0] res;
    res = line;
    for (int k = 0; k < BURST; k++) begin
      if (idx == k[1:0]) begin
        res[k*BEAT_W +: BEAT_W] = beat;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign accept_s = rvalid & rready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RIDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, lane/id capture and protocol-error detection.
  always_comb begin
    state_nxt_s    = state_r;
    beat_cnt_nxt_s = beat_cnt_r;
    line_nxt_s     = rdata_m_data;
    id_nxt_s       = rdata_m_id;
    err_set_s      = 1'b0;
    case (state_r)
      RIDLE: begin
        if (accept_s) begin
          line_nxt_s     = lane_write(rdata_m_data, 2'd0, rdata);
          id_nxt_s       = rid;
          beat_cnt_nxt_s = 2'd1;
          if (rlast) begin
            state_nxt_s = RHOLD;
            err_set_s   = 1'b1;
          end else begin
            state_nxt_s = RRECV;
          end
        end else begin
          state_nxt_s = RIDLE;
        end
      end
      RRECV: begin
        if (accept_s) begin
          line_nxt_s = lane_write(rdata_m_data, beat_cnt_r, rdata);
          // A mismatching rid still lands its data; the captured id is kept.
          if (rid != rdata_m_id) begin
            err_set_s = 1'b1;
          end else begin
            err_set_s = 1'b0;
          end
          if (beat_cnt_r == 2'd3) begin
            state_nxt_s = RHOLD;
            if (!rlast) begin
              err_set_s = 1'b1;
            end else begin
              err_set_s = err_set_s;
            end
          end else if (rlast) begin
            state_nxt_s = RHOLD;
            err_set_s   = 1'b1;
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + 2'd1;
          end
        end else begin
          state_nxt_s = RRECV;
        end
      end
      RHOLD: begin
        if (rdata_m_ack) begin
          state_nxt_s    = RIDLE;
          beat_cnt_nxt_s = 2'd0;
          line_nxt_s     = '0;
        end else begin
          state_nxt_s = RHOLD;
        end
      end
      RDEFO: begin
        state_nxt_s    = RIDLE;
        beat_cnt_nxt_s = 2'd0;
        line_nxt_s     = '0;
      end
      default: begin
        state_nxt_s    = RIDLE;
        beat_cnt_nxt_s = 2'd0;
        line_nxt_s     = '0;
      end
    endcase

    // A fresh error outranks a simultaneous clear.
    if (err_set_s) begin
      err_nxt_s = 1'b1;
    end else if (err_clr) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = rdata_m_err;
    end
  end

  // Registered outputs: handshake decoded from the next state, never from rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_r    <= 2'd0;
      rready        <= 1'b0;
      rdata_m_valid <= 1'b0;
      rdata_m_id    <= '0;
      rdata_m_data  <= '0;
      rdata_m_err   <= 1'b0;
    end else begin
      beat_cnt_r    <= beat_cnt_nxt_s;
      rready        <= (state_nxt_s == RIDLE) || (state_nxt_s == RRECV);
      rdata_m_valid <= (state_nxt_s == RHOLD);
      rdata_m_id    <= id_nxt_s;
      rdata_m_data  <= line_nxt_s;
      rdata_m_err   <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_rdata_chan_mngr.sv
// Self-checking bench for rdata_chan_mngr: directed bursts plus randomized bursts
// checked against a burst-level reference model.
module tb_rdata_chan_mngr;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [3:0]   rid = 4'd0;
  logic [31:0]  rdata = 32'd0;
  logic         rlast = 1'b0;
  logic         rdata_m_valid;
  logic [3:0]   rdata_m_id;
  logic [127:0] rdata_m_data;
  logic         rdata_m_ack = 1'b0;
  logic         rdata_m_err;
  logic         err_clr = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] bd[4];
  logic [3:0]  bid[4];
  logic        blast[4];
  logic        m_err = 1'b0;

  rdata_chan_mngr dut (
    .clk(clk), .rst(rst), .rvalid(rvalid), .rready(rready), .rid(rid),
    .rdata(rdata), .rlast(rlast), .rdata_m_valid(rdata_m_valid),
    .rdata_m_id(rdata_m_id), .rdata_m_data(rdata_m_data),
    .rdata_m_ack(rdata_m_ack), .rdata_m_err(rdata_m_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Index of the beat that ends the burst: first rlast among beats 0..2, else beat 3.
  function automatic int term_idx();
    for (int i = 0; i < 3; i++) if (blast[i]) return i;
    return 3;
  endfunction

  task automatic check_idle_outputs(input string tag, input logic exp_rready);
    check_eq({tag, "_rready"}, {127'd0, rready}, {127'd0, exp_rready});
    check_eq({tag, "_valid"}, {127'd0, rdata_m_valid}, 128'd0);
    check_eq({tag, "_data"}, rdata_m_data, 128'd0);
    check_eq({tag, "_id"}, {124'd0, rdata_m_id}, 128'd0);
    check_eq({tag, "_err"}, {127'd0, rdata_m_err}, 128'd0);
  endtask

  // Present beat i at a negedge and hold it until it is accepted; returns at the next negedge.
  task automatic send_beat(input int i);
    int waited;
    rvalid = 1'b1; rdata = bd[i]; rid = bid[i]; rlast = blast[i];
    waited = 0;
    while (!rready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!rready) check_eq("beat_accept_timeout", 128'd0, 128'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_burst(input int max_gap, input int hold_cyc, input bit do_clr);
    int t;
    logic [127:0] line;
    logic [3:0] eid;
    bit berr;
    t = term_idx();
    line = '0;
    eid = bid[0];
    berr = 1'b0;
    for (int i = 0; i <= t; i++) begin
      line[32*i +: 32] = bd[i];
      if (i > 0 && bid[i] != bid[0]) berr = 1'b1;
    end
    if (t < 3 || !blast[3]) berr = 1'b1;
    m_err = m_err | berr;

    for (int i = 0; i <= t; i++) begin
      send_beat(i);
      rdata_m_ack = 1'($urandom_range(0, 1));
      if (i < t) begin
        repeat ($urandom_range(0, max_gap)) begin
          rvalid = 1'b0; rdata = $urandom; rlast = 1'($urandom_range(0, 1));
          rid = 4'($urandom);
          @(negedge clk);
        end
      end
    end

    rdata_m_ack = 1'b0;
    rvalid = 1'b1; rdata = $urandom; rid = 4'($urandom); rlast = 1'b1;
    check_eq("hold_valid", {127'd0, rdata_m_valid}, 128'd1);
    check_eq("hold_data", rdata_m_data, line);
    check_eq("hold_id", {124'd0, rdata_m_id}, {124'd0, eid});
    check_eq("hold_err", {127'd0, rdata_m_err}, {127'd0, m_err});
    check_eq("hold_rready", {127'd0, rready}, 128'd0);
    repeat (hold_cyc) begin
      @(negedge clk);
      rdata = $urandom;
      check_eq("hold_wait_rready", {127'd0, rready}, 128'd0);
      check_eq("hold_wait_data", rdata_m_data, line);
      check_eq("hold_wait_valid", {127'd0, rdata_m_valid}, 128'd1);
    end
    if (do_clr) begin
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_err = 1'b0;
      check_eq("err_clr", {127'd0, rdata_m_err}, 128'd0);
    end
    rdata_m_ack = 1'b1;
    @(negedge clk);
    rdata_m_ack = 1'b0;
    rvalid = 1'b0;
    check_eq("ack_valid", {127'd0, rdata_m_valid}, 128'd0);
    check_eq("ack_rready", {127'd0, rready}, 128'd1);
    check_eq("ack_data_cleared", rdata_m_data, 128'd0);
    check_eq("ack_err", {127'd0, rdata_m_err}, {127'd0, m_err});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("in_reset", 1'b0);
    rst = 1'b0;
    #1;
    check_eq("rready_at_release", {127'd0, rready}, 128'd0);
    @(negedge clk);
    check_idle_outputs("after_release", 1'b1);

    // Full in-order burst; hold five cycles with rvalid asserted.
    bd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    bid = '{4'd5, 4'd5, 4'd5, 4'd5};
    blast = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_burst(0, 5, 1'b0);

    // Early rlast on beat 1, then clear the error.
    bd = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
    bid = '{4'd2, 4'd2, 4'd2, 4'd2};
    blast = '{1'b0, 1'b1, 1'b0, 1'b0};
    run_burst(0, 1, 1'b1);

    // rid changes on beat 2.
    bd = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
    bid = '{4'd3, 4'd3, 4'd7, 4'd3};
    blast = '{1'b0, 1'b0, 1'b0, 1'b1};
    run_burst(1, 1, 1'b1);

    // Reset mid-burst after three beats, then a clean burst.
    bd = '{32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003};
    bid = '{4'd9, 4'd9, 4'd9, 4'd9};
    blast = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) send_beat(i);
    rvalid = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_burst_reset", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_err = 1'b0;
    bd = '{32'h0000000F, 32'h000000F0, 32'h00000F00, 32'h0000F000};
    bid = '{4'd1, 4'd1, 4'd1, 4'd1};
    run_burst(0, 0, 1'b0);
    // Early rlast on beat 0 and missing rlast on beat 3.
    bd = '{32'h12345678, 32'h0, 32'h0, 32'h0};
    blast = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_burst(0, 0, 1'b1);
    bd = '{32'h1, 32'h2, 32'h3, 32'h4};
    blast = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_burst(0, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        bd[i] = $urandom;
        bid[i] = 4'($urandom);
        blast[i] = (i == 3);
      end
      for (int i = 1; i < 4; i++) begin
        if ($urandom_range(0, 9) < 8) bid[i] = bid[0];
      end
      if ($urandom_range(0, 9) < 3) begin
        for (int i = 0; i < 4; i++) blast[i] = 1'($urandom_range(0, 1));
      end
      run_burst(2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
